// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_STEP        = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_ctrl_pc_next_sel.sv
// Redirect target selection (jump beats branch), word alignment and sequential pc+4.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    output logic             redirect,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_inc
);

    logic [WIDTH-1:0] raw_target;

    assign redirect   = jump_valid | branch_taken;
    assign raw_target = jump_valid ? jump_target : branch_target;
    assign target     = {raw_target[WIDTH-1:2], 2'b00};
    // Wraps naturally modulo 2^WIDTH.
    assign pc_inc     = pc + WIDTH'(PC_STEP);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// PC register, single-outstanding fetch FSM and one-entry instruction buffer.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready
);

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] pc, pc_next;
    logic [WIDTH-1:0] req_pc, req_pc_next;
    logic [WIDTH-1:0] instr_next, instr_pc_next;
    logic             kill, kill_next;
    logic             redirect;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_inc;

    pc_next_sel #(.WIDTH(WIDTH)) u_pc_next_sel (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (target),
        .pc_inc        (pc_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            kill     <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_pc   <= req_pc_next;
            kill     <= kill_next;
            instr    <= instr_next;
            instr_pc <= instr_pc_next;
        end
    end

    // A kill marks the single in-flight request as stale so its response is dropped.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_pc_next   = req_pc;
        kill_next     = kill;
        instr_next    = instr;
        instr_pc_next = instr_pc;

        case (state)
            IDLE: begin
                if (redirect) pc_next = target;
                state_next = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    if (redirect) begin
                        kill_next = 1'b1;
                        pc_next   = target;
                    end else begin
                        req_pc_next = pc;
                        pc_next     = pc_inc;
                    end
                    state_next = WAIT;
                end else if (redirect) begin
                    pc_next = target;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill || redirect) begin
                        kill_next  = 1'b0;
                        if (redirect) pc_next = target;
                        state_next = REQ;
                    end else begin
                        instr_next    = imem_rsp_data;
                        instr_pc_next = req_pc;
                        state_next    = HOLD;
                    end
                end else if (redirect) begin
                    kill_next = 1'b1;
                    pc_next   = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = REQ;
                end else if (instr_ready) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    // Masked by redirect so decode never takes a squashed instruction.
    assign instr_valid    = (state == HOLD) && !redirect;

    rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (state == WAIT));

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: expected requests/instructions are queued, a monitor checks them.
module tb_fetch_pc_ctrl;

    localparam int unsigned WIDTH    = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        int          gap;
    } exp_instr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          last_accept = 0;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_req_q[$];
    exp_instr_t  exp_instr_q[$];
    exp_instr_t  mon_e;

    fetch_pc_ctrl #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [31:0] actual);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got %h, expected nothing", name, actual);
    endtask

    task automatic applyStimulus(input logic jv, input logic [31:0] jt, input logic bt, input logic [31:0] btgt);
        jump_valid    = jv;
        jump_target   = jt;
        branch_taken  = bt;
        branch_target = btgt;
    endtask

    task automatic drainAndPark(input string name);
        int waited = 0;
        while ((exp_req_q.size() != 0 || exp_instr_q.size() != 0) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checkOutput(name, 32'(exp_req_q.size() + exp_instr_q.size()), 32'd0);
        exp_req_q.delete();
        exp_instr_q.delete();
        imem_req_ready = 1'b0;
    endtask

    task automatic parkAt(input logic [31:0] addr);
        @(negedge clk);
        applyStimulus(1'b1, addr, 1'b0, '0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
    endtask

    task automatic pushInstr(input logic [31:0] pc, input int gap);
        exp_instr_t e;
        e.pc  = pc;
        e.gap = gap;
        exp_instr_q.push_back(e);
    endtask

    // Instruction memory: answers each accepted request mem_lat cycles later.
    always begin
        @(negedge clk);
        if (mem_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_addr);
        end else begin
            imem_rsp_valid = 1'b0;
        end
        if (mem_cnt > 0) mem_cnt--;
        #4;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            mem_addr = imem_req_addr;
            mem_cnt  = mem_lat;
        end
    end

    // Monitor pops the scoreboard on every request handshake and every decode accept.
    always begin
        @(negedge clk);
        #4;
        cycle++;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            if (exp_req_q.size() == 0) reportUnexpected("unexpected_req", imem_req_addr);
            else checkOutput("req_addr", imem_req_addr, exp_req_q.pop_front());
        end
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_instr_q.size() == 0) begin
                reportUnexpected("unexpected_accept", instr_pc);
            end else begin
                mon_e = exp_instr_q.pop_front();
                checkOutput("instr_pc", instr_pc, mon_e.pc);
                checkOutput("instr_data", instr, word_of(mon_e.pc));
                if (mon_e.gap != 0) checkOutput("accept_gap", 32'(cycle - last_accept), 32'(mon_e.gap));
            end
            last_accept = cycle;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        #4;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_instr_pc", instr_pc, 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);

        // Straight-line run from reset.
        @(negedge clk);
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h4);
        exp_req_q.push_back(32'h8);
        pushInstr(32'h0, 0);
        pushInstr(32'h4, 3);
        pushInstr(32'h8, 3);
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        rst_n          = 1'b1;
        drainAndPark("drain_straight");

        // Branch during WAIT drops the in-flight response; target is aligned.
        @(negedge clk);
        exp_req_q.push_back(32'hC);
        exp_req_q.push_back(32'h100);
        pushInstr(32'h100, 0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, 32'h103);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
        drainAndPark("drain_branch_wait");

        // Jump during WAIT before the response arrives: killed response is dropped later.
        @(negedge clk);
        exp_req_q.push_back(32'h104);
        exp_req_q.push_back(32'h180);
        pushInstr(32'h180, 0);
        mem_lat        = 2;
        imem_req_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 32'h180, 1'b0, '0);
        mem_lat = 1;
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
        drainAndPark("drain_kill_wait");

        // Jump and branch together: jump wins.
        @(negedge clk);
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h300);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
        exp_req_q.push_back(32'h200);
        pushInstr(32'h200, 0);
        imem_req_ready = 1'b1;
        #4;
        checkOutput("jump_wins_addr", imem_req_addr, 32'h200);
        drainAndPark("drain_jump_wins");

        // Stall in HOLD, then redirect coinciding with instr_ready.
        instr_ready = 1'b0;
        @(negedge clk);
        exp_req_q.push_back(32'h204);
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #4;
            checkOutput("hold_valid", 32'(instr_valid), 32'd1);
            checkOutput("hold_pc", instr_pc, 32'h204);
            checkOutput("hold_data", instr, word_of(32'h204));
            @(negedge clk);
        end
        instr_ready = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 32'h40);
        exp_req_q.push_back(32'h40);
        pushInstr(32'h40, 0);
        #4;
        checkOutput("squash_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
        drainAndPark("drain_hold_redirect");

        // PC wrap at the top of the address space.
        parkAt(32'hFFFF_FFFF);
        exp_req_q.push_back(32'hFFFF_FFFC);
        exp_req_q.push_back(32'h0);
        pushInstr(32'hFFFF_FFFC, 0);
        pushInstr(32'h0, 3);
        imem_req_ready = 1'b1;
        drainAndPark("drain_wrap");

        // Reset during WAIT; the late response lands while in reset and is ignored.
        @(negedge clk);
        exp_req_q.push_back(32'h4);
        mem_lat        = 2;
        imem_req_ready = 1'b1;
        @(negedge clk);
        mem_lat = 1;
        #2;
        rst_n = 1'b0;
        #2;
        checkOutput("arst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("arst_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #4;
        checkOutput("arst_rsp_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("arst_rsp_req_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_req_q.push_back(RESET_PC);
        pushInstr(RESET_PC, 0);
        #3;
        checkOutput("post_rst_idle_valid", 32'(instr_valid), 32'd0);
        checkOutput("post_rst_idle_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #4;
        checkOutput("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("post_rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("post_rst_instr_valid", 32'(instr_valid), 32'd0);
        drainAndPark("drain_reset_wait");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
